// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and widths for the MAC sequencer
package mac_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_ACC_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } mac_seq_state_t;

endpackage

// File: rtl/mac_en_align.sv
// rtl/mac_en_align.sv - DEPTH-stage delay line for the accumulate enable, with synchronous flush
module mac_en_align #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic strobe_i,
  output logic enable_o
);

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = '0;
    sr_d[0] = strobe_i;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign enable_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product job sequencer owning the MAC datapath control pins
// MAC_SEQ_SAT_EN: when defined, res_data reads 16'hFFFF whenever the job overflowed.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [MAC_DATA_W-1:0] in_a,
  input  logic [MAC_DATA_W-1:0] in_b,
  output logic                  in_ready,
  output logic [MAC_DATA_W-1:0] mac_a,
  output logic [MAC_DATA_W-1:0] mac_b,
  output logic                  mac_enable,
  output logic                  mac_clear,
  input  logic [MAC_ACC_W-1:0]  mac_result,
  input  logic                  mac_overflow,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [MAC_ACC_W-1:0]  res_data,
  output logic                  res_ovf,
  output logic                  busy,
  output logic                  len_err
);

  localparam int DRN_W = $clog2(PIPE_LAT + 1);

  mac_seq_state_t        state_q, state_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic [DRN_W-1:0]      drain_q, drain_d;
  logic [MAC_DATA_W-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic                  clear_q, clear_d;
  logic                  res_valid_q, res_valid_d;
  logic [MAC_ACC_W-1:0]  res_data_q, res_data_d;
  logic                  ovf_q, ovf_d;
  logic                  len_err_q, len_err_d;
  logic                  accept;
  logic                  do_abort;

  assign do_abort = abort && (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    clear_d     = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    ovf_d       = ovf_q;
    len_err_d   = 1'b0;
    accept      = 1'b0;

    if (do_abort) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              len_err_d = 1'b1;
            end else begin
              remaining_d = len;
              clear_d     = 1'b1;
              state_d     = ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          ovf_d   = 1'b0;
          state_d = ST_STREAM;
        end
        ST_STREAM: begin
          ovf_d = ovf_q | mac_overflow;
          if (in_valid) begin
            accept      = 1'b1;
            mac_a_d     = in_a;
            mac_b_d     = in_b;
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              drain_d = '0;
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          ovf_d = ovf_q | mac_overflow;
          // Last enable has landed once PIPE_LAT+1 drain cycles have elapsed.
          if (drain_q == DRN_W'(PIPE_LAT)) begin
`ifdef MAC_SEQ_SAT_EN
            res_data_d = ovf_d ? {MAC_ACC_W{1'b1}} : mac_result;
`else
            res_data_d = mac_result;
`endif
            res_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            drain_d = drain_q + DRN_W'(1);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      drain_q     <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      clear_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      ovf_q       <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      clear_q     <= clear_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      ovf_q       <= ovf_d;
      len_err_q   <= len_err_d;
    end
  end

  // The operand register is the first stage, so the enable leaves alongside mac_a for PIPE_LAT=1.
  mac_en_align #(.DEPTH(PIPE_LAT)) u_en_align (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (do_abort),
    .strobe_i (accept),
    .enable_o (mac_enable)
  );

  assign in_ready  = (state_q == ST_STREAM);
  assign busy      = (state_q != ST_IDLE);
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_clear = clear_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = ovf_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - self-checking bench for mac_seq_ctrl with a behavioural MAC datapath
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid, res_ready;
  logic [7:0]  len, in_a, in_b, mac_a, mac_b;
  logic        in_ready, mac_enable, mac_clear, mac_overflow;
  logic [15:0] mac_result, res_data;
  logic        res_valid, res_ovf, busy, len_err;

  int n_chk = 0;
  int n_fail = 0;
  int en_total = 0;

  logic [7:0] ja [0:15];
  logic [7:0] jb [0:15];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.LEN_W(8), .PIPE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_enable(mac_enable), .mac_clear(mac_clear),
    .mac_result(mac_result), .mac_overflow(mac_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .busy(busy), .len_err(len_err)
  );

  // Datapath stand-in: accumulator with wrap and sticky carry-out.
  logic [15:0] dp_acc;
  logic        dp_ovf;
  logic [16:0] dp_sum;
  assign dp_sum = {1'b0, dp_acc} + {1'b0, 16'(mac_a) * 16'(mac_b)};
  always @(posedge clk) begin
    if (rst || mac_clear) begin
      dp_acc <= 16'd0;
      dp_ovf <= 1'b0;
    end else if (mac_enable) begin
      dp_acc <= dp_sum[15:0];
      dp_ovf <= dp_ovf | dp_sum[16];
    end
  end
  assign mac_result   = dp_acc;
  assign mac_overflow = dp_ovf;

  always @(posedge clk) if (mac_enable) en_total <= en_total + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input int n, output logic [15:0] d, output logic o);
    int sum;
    sum = 0;
    for (int i = 0; i < n; i++) sum += int'(ja[i]) * int'(jb[i]);
    o = (sum > 65535);
`ifdef MAC_SEQ_SAT_EN
    d = o ? 16'hFFFF : 16'(sum);
`else
    d = 16'(sum);
`endif
  endtask

  task automatic run_job(input string nm, input int n, input int bub, input int hold,
                         input logic [15:0] ed, input logic eo, input int elat);
    int lat, guard, en0;
    en0 = en_total;
    len = 8'(n); start = 1'b1;
    tick();
    start = 1'b0; lat = 1;
    chk({nm, "_clear"}, 32'(mac_clear), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (bub == 1 || (bub == 2 && $urandom_range(0, 2) == 0))) begin
        in_valid = 1'b0;
        tick(); lat++;
      end
      in_valid = 1'b1; in_a = ja[i]; in_b = jb[i];
      guard = 0;
      while (!in_ready && guard < 20) begin tick(); lat++; guard++; end
      tick(); lat++;
    end
    in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
    guard = 0;
    while (!res_valid && guard < 50) begin tick(); lat++; guard++; end
    chk({nm, "_valid"}, 32'(res_valid), 32'd1);
    if (elat > 0) chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_data"}, 32'(res_data), 32'(ed));
    chk({nm, "_ovf"}, 32'(res_ovf), 32'(eo));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({nm, "_hold"}, {15'd0, res_valid, res_data}, {15'd0, 1'b1, ed});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({nm, "_idle"}, {30'd0, busy, res_valid}, 32'd0);
    chk({nm, "_enables"}, 32'(en_total - en0), 32'(n));
  endtask

  typedef struct {
    int               n;
    int               bub;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [15:0]      d;
    logic             o;
    int               lat;
  } vec_t;

  vec_t vt [0:3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] md;
    logic        mo;
    logic        seen;
    int          n, guard;

    vt[0] = '{n: 3, bub: 0, a: {8'd0, 8'd1, 8'd4, 8'd2}, b: {8'd0, 8'd1, 8'd5, 8'd3},
              d: 16'd27, o: 1'b0, lat: 7};
    vt[1] = '{n: 4, bub: 1, a: {4{8'd10}}, b: {4{8'd10}}, d: 16'd400, o: 1'b0, lat: 0};
`ifdef MAC_SEQ_SAT_EN
    vt[2] = '{n: 2, bub: 0, a: {4{8'd255}}, b: {4{8'd255}}, d: 16'hFFFF, o: 1'b1, lat: 6};
`else
    vt[2] = '{n: 2, bub: 0, a: {4{8'd255}}, b: {4{8'd255}}, d: 16'hFC02, o: 1'b1, lat: 6};
`endif
    vt[3] = '{n: 1, bub: 0, a: {4{8'd7}}, b: {4{8'd7}}, d: 16'd49, o: 1'b0, lat: 5};

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    len = 8'd0; in_a = 8'd0; in_b = 8'd0;
    tick(); tick();
    chk("reset_ctrl", {25'd0, in_ready, mac_enable, mac_clear, res_valid, res_ovf, busy, len_err}, 32'd0);
    chk("reset_data", {mac_a, mac_b, res_data}, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 4; j++) begin ja[j] = vt[v].a[j]; jb[j] = vt[v].b[j]; end
      run_job($sformatf("vec%0d", v), vt[v].n, vt[v].bub, 1, vt[v].d, vt[v].o, vt[v].lat);
    end

    ja[0] = 8'd3; jb[0] = 8'd3;
    run_job("b2b_first", 1, 0, 5, 16'd9, 1'b0, 5);
    ja[0] = 8'd1; jb[0] = 8'd2;
    run_job("b2b_second", 1, 0, 0, 16'd2, 1'b0, 5);

    for (int j = 0; j < 3; j++) begin ja[j] = 8'd5; jb[j] = 8'd5; end
    len = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5;
    guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    tick();
    in_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin tick(); seen = seen | res_valid; end
    chk("abort_no_valid", 32'(seen), 32'd0);
    ja[0] = 8'd7; jb[0] = 8'd7;
    run_job("abort_next", 1, 0, 0, 16'd49, 1'b0, 5);

    len = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_err", {30'd0, len_err, busy}, {30'd0, 1'b1, 1'b0});
    tick();
    chk("len0_pulse", {30'd0, len_err, busy}, 32'd0);

    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        ja[j] = 8'($urandom_range(0, 255));
        jb[j] = 8'($urandom_range(0, 255));
      end
      model(n, md, mo);
      run_job($sformatf("rand%0d", r), n, 2, $urandom_range(0, 2), md, mo, 0);
    end

    len = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
    chk("midrst_ctrl", {25'd0, in_ready, mac_enable, mac_clear, res_valid, res_ovf, busy, len_err}, 32'd0);
    chk("midrst_data", {mac_a, mac_b, res_data}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
